sw_debounce: RTL and testbench

//   Conditions the raw slide-switch inputs before they reach the VGA colour stage.
//   Per channel: 2-flop synchroniser, then a counter-based debounce FSM.

---
 rtl/sw_debounce_pkg.sv | 11 +
 rtl/debounce_channel.sv | 71 +++++++
 rtl/sw_debounce.sv | 26 ++
 tb/tb_sw_debounce.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared FSM state encoding and default debounce constants
package sw_debounce_pkg;
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    ARM_HI  = 2'd1,
    IDLE_HI = 2'd2,
    ARM_LO  = 2'd3
  } db_state_e;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF = 20;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-flop synchroniser plus counter-based debounce FSM for one switch bit
module debounce_channel
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic s1, s2, done, rise_nxt, fall_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  db_state_e state, state_nxt;
  assign done = cnt == LAST;
  assign db = state[1];
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    case (state)
      IDLE_LO: if (s2) begin
        state_nxt = ARM_HI;
        cnt_nxt = ONE;
      end
      ARM_HI: if (!s2) begin
        state_nxt = IDLE_LO;
        cnt_nxt = '0;
      end else if (done) begin
        state_nxt = IDLE_HI;
        rise_nxt = 1'b1;
        cnt_nxt = '0;
      end else cnt_nxt = cnt + ONE;
      IDLE_HI: if (!s2) begin
        state_nxt = ARM_LO;
        cnt_nxt = ONE;
      end
      default: if (s2) begin
        state_nxt = IDLE_HI;
        cnt_nxt = '0;
      end else if (done) begin
        state_nxt = IDLE_LO;
        fall_nxt = 1'b1;
        cnt_nxt = '0;
      end else cnt_nxt = cnt + ONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= IDLE_LO;
      cnt <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      state <= state_nxt;
      cnt <= cnt_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: N_CH independent switch debouncers producing clean levels and rise/fall strobes
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int N_CH = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk_50MHz,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_db,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ch (
      .clk (clk_50MHz),
      .rst (rst),
      .sw  (sw_in[i]),
      .db  (sw_db[i]),
      .rise(sw_rise[i]),
      .fall(sw_fall[i])
    );
  end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: randomized and directed checks of sw_debounce against a run-length reference model
module tb_sw_debounce;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] sw_in = 3'b111;
  logic [2:0] sw_db, sw_rise, sw_fall;
  int checks = 0;
  int errors = 0;
  logic [2:0] m_s1, m_s2, m_db, m_rise, m_fall;
  int run [3];
  bit started = 1'b0;
  logic [2:0] acc_rise, acc_fall;
  int n_rise1;
  sw_debounce #(.N_CH(3), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk_50MHz(clk),
    .rst(rst),
    .sw_in(sw_in),
    .sw_db(sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );
  always #10 clk = ~clk;
  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < 3; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        run[i] = (m_s2[i] != m_db[i]) ? run[i] + 1 : 0;
        if (run[i] == D) begin
          m_db[i] = ~m_db[i];
          m_rise[i] = m_db[i];
          m_fall[i] = ~m_db[i];
          run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_in;
    end
    started = 1'b1;
  end
  always @(negedge clk) begin
    if (started) begin
      chk("model_db", sw_db, m_db);
      chk("model_rise", sw_rise, m_rise);
      chk("model_fall", sw_fall, m_fall);
      acc_rise = acc_rise | sw_rise;
      acc_fall = acc_fall | sw_fall;
      if (sw_rise[1]) n_rise1++;
    end
  end
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clr_acc();
    acc_rise = '0;
    acc_fall = '0;
    n_rise1 = 0;
  endtask
  initial begin
    clr_acc();
    wait_n(3);
    chk("reset_db", sw_db, 3'b000);
    chk("reset_strobes", sw_rise | sw_fall, 3'b000);
    rst = 1'b1;
    wait_n(9);
    chk("t1_db_e9", sw_db, 3'b000);
    wait_n(1);
    chk("t1_db_e10", sw_db, 3'b111);
    chk("t1_rise_e10", sw_rise, 3'b111);
    wait_n(1);
    chk("t1_rise_e11", sw_rise, 3'b000);
    sw_in = 3'b110;
    wait_n(9);
    chk("t5_db_e9", sw_db, 3'b111);
    wait_n(1);
    chk("t5_db_e10", sw_db, 3'b110);
    chk("t5_fall_e10", sw_fall, 3'b001);
    wait_n(1);
    chk("t5_fall_e11", sw_fall, 3'b000);
    sw_in = 3'b111;
    wait_n(10);
    chk("t2_db", sw_db, 3'b111);
    chk("t2_rise", sw_rise, 3'b001);
    wait_n(1);
    chk("t2_rise_off", sw_rise, 3'b000);
    sw_in = 3'b110;
    clr_acc();
    wait_n(4);
    rst = 1'b0;
    wait_n(1);
    chk("t5r_db", sw_db, 3'b000);
    chk("t5r_strobes", acc_fall | sw_rise, 3'b000);
    sw_in = 3'b000;
    rst = 1'b1;
    wait_n(12);
    chk("t5r_db_after", sw_db, 3'b000);
    sw_in = 3'b101;
    clr_acc();
    wait_n(10);
    chk("t6_rise", sw_rise, 3'b101);
    chk("t6_db", sw_db, 3'b101);
    wait_n(1);
    chk("t6_rise_off", sw_rise, 3'b000);
    sw_in = 3'b000;
    wait_n(12);
    chk("t4_pre_db", sw_db, 3'b000);
    clr_acc();
    sw_in[2] = 1'b1;
    wait_n(7);
    sw_in[2] = 1'b0;
    wait_n(20);
    chk("t4_db", sw_db, 3'b000);
    chk("t4_strobes", acc_rise | acc_fall, 3'b000);
    clr_acc();
    foreach (sw_in[k]) sw_in[k] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sw_in[1] = (k == 1 || k == 4) ? 1'b0 : 1'b1;
      wait_n(1);
    end
    sw_in[1] = 1'b1;
    wait_n(9);
    chk("t3_db_e9", sw_db, 3'b000);
    wait_n(1);
    chk("t3_rise_e10", sw_rise, 3'b010);
    wait_n(5);
    checks++;
    if (n_rise1 != 1) begin
      errors++;
      $display("FAIL t3_rise_count: got %0d expected 1", n_rise1);
    end
    chk("t3_no_fall", acc_fall, 3'b000);
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        rst = 1'b0;
        wait_n($urandom_range(1, 3));
        rst = 1'b1;
      end else if (r < 40) begin
        sw_in = 3'($urandom);
      end else if (r < 60) begin
        for (int g = 0; g < $urandom_range(2, 12); g++) begin
          sw_in[$urandom_range(0, 2)] = 1'($urandom);
          wait_n($urandom_range(1, 9));
        end
      end
      wait_n(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
